// File: rtl/decode_pkg.sv
// Shared types for the RV32/RV64 decode stage:
// format codes, opcodes, FIFO states and the stored entry.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // pc and imm are sized for the widest datapath; the
    // stage casts them down to its own XLEN.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        fmt_t                fmt;
        logic                illegal;
    } entry_t;

    function automatic fmt_t fmt_of(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_REG:    f = FMT_R;
            OP_IMM:    f = FMT_I;
            OP_LOAD:   f = FMT_I;
            OP_JALR:   f = FMT_I;
            OP_SYSTEM: f = FMT_I;
            OP_STORE:  f = FMT_S;
            OP_BRANCH: f = FMT_B;
            OP_LUI:    f = FMT_U;
            OP_AUIPC:  f = FMT_U;
            OP_JAL:    f = FMT_J;
            default:   f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the format's immediate
// and sign-extends it from instruction bit 31 to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_t            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Scatter/gather of immediate bits per format
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25],
                            instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31],
                            instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31],
                            instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'(signed'(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes at input acceptance and buffers
// results in a 2-entry head/skid FIFO feeding execute.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit HOLD_ILLEGAL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    occ_t            occ;
    entry_t          head;
    entry_t          skid;
    entry_t          fresh;
    fmt_t            fmt;
    logic [XLEN-1:0] imm;
    logic            in_fire;
    logic            out_fire;
    logic            push;

    assign fmt = fmt_of(in_instr[6:0]);

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    // Decoded entry for the word currently offered upstream
    always_comb begin
        fresh         = '0;
        fresh.pc      = XLEN_MAX'(in_pc);
        fresh.imm     = XLEN_MAX'(imm);
        fresh.opcode  = in_instr[6:0];
        fresh.rd      = in_instr[11:7];
        fresh.funct3  = in_instr[14:12];
        fresh.rs1     = in_instr[19:15];
        fresh.rs2     = in_instr[24:20];
        fresh.funct7  = in_instr[31:25];
        fresh.fmt     = fmt;
        fresh.illegal = (fmt == FMT_ILL);
    end

    // Handshakes depend only on stored occupancy
    assign in_ready  = (occ != OCC_TWO);
    assign out_valid = (occ != OCC_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign push      = in_fire &&
                       (HOLD_ILLEGAL || !fresh.illegal);

    // Occupancy and head/skid storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            skid <= '0;
        end else if (flush) begin
            occ <= OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= fresh;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && out_fire) begin
                        head <= fresh;
                    end else if (push) begin
                        skid <= fresh;
                        occ  <= OCC_TWO;
                    end else if (out_fire) begin
                        occ <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_fire) begin
                        head <= skid;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    assign out_pc      = XLEN'(head.pc);
    assign out_imm     = XLEN'(head.imm);
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

endmodule
